mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: turns byte-addressed load/store requests from the MIPS execute stage into word-indexed, one-cycle-latency memory reads and writes.
- Supports byte, halfword and word access. Loads are sign- or zero-extended.
- Sub-word stores use read-modify-write, because the memory only writes whole words.
- The memory corrupts the addressed word in any cycle where neither read nor write is asserted, so this block never issues such a cycle.

Parameters:
- ADDR_W, 6, number of word-index bits driven on mem_addr (memory depth = 2^ADDR_W words)

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; = (state==IDLE) && !reset
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse marking completion
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected; no memory access performed
- mem_addr  out  32  word index {zeros, req_addr[ADDR_W+1:2]}
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid the cycle after mem_read is registered

Behaviour:
- Reset values: resp_valid 0, resp_rdata 0, resp_err 0, mem_write 0, mem_read 1, mem_addr 0, mem_wdata 0, state IDLE.
- Reset mid-operation aborts the transaction. No response is issued. mem_write is 0 from the next cycle.
- All memory-side outputs and all response outputs are registered.
- Invariant: mem_read = !mem_write in every cycle, including reset. mem_addr holds its last value when idle.
- States: IDLE, RD, DATA, WR, RESP.
- A request is accepted on an edge where req_valid && req_ready. Request fields are captured at that edge.
- Error check at acceptance: size 11, half with addr[0]=1, or word with addr[1:0]≠0. On error: IDLE→RESP, resp_err=1, resp_rdata=0.
- Load: IDLE→RD→DATA→RESP.
  - RD: mem_read=1 with the word index.
  - DATA: extract the lane from mem_rdata and register it into resp_rdata.
  - resp_valid is high in the 3rd cycle after the accepting edge.
- Word store: IDLE→WR→RESP.
  - WR: mem_write=1, mem_wdata=req_wdata.
  - resp_valid is high in the 2nd cycle after the accepting edge.
- Sub-word store: IDLE→RD→DATA→WR→RESP.
  - DATA: merge the new lane into mem_rdata and keep the other bytes unchanged.
  - resp_valid is high in the 4th cycle after the accepting edge.
- Error: resp_valid is high in the 1st cycle after the accepting edge.
- RESP→IDLE always. resp_valid is high only in RESP. resp_err and resp_rdata are cleared to 0 on leaving RESP.
- Lanes are little-endian: byte k = bits [8k+7:8k] with k = addr[1:0]; halfword = bits [16h+15:16h] with h = addr[1].
- Sign extension replicates the lane MSB. Zero extension pads with 0. req_unsigned is ignored for word loads and for stores.
- Upper address bits above ADDR_W+1 are ignored (wrap-around) unless the optional feature is enabled.

Optional Feature:
- Macro: MAU_RANGE_CHECK_EN.
- Defined: any request with req_addr[31:ADDR_W+2] ≠ 0 is treated as an error at acceptance (no memory access, resp_err=1, 1-cycle latency).
- Not defined: those bits are discarded and the access wraps to word index req_addr[ADDR_W+1:2].

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10; lw @0x10 → mem_write with mem_addr=4 in cycle 1; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at cycle +3.
- Sub-word store merge: word@0x20=0x11223344; sb 0xAA @0x21 → memory word 0x1122AA44; sh 0xBEEF @0x22 → 0xBEEFAA44; resp at cycle +4.
- Load extension: word=0x80FF7F01; lb @0 → 0x00000001; lb @2 → 0xFFFFFFFF; lbu @2 → 0x000000FF; lh @2 → 0xFFFF80FF; lhu @2 → 0x000080FF.
- Alignment errors: lh @0x3, lw @0x2, size 11 → resp_err=1, resp_rdata=0 one cycle after accept; mem_write never asserted; target word unchanged.
- Read-strobe invariant: random requests with idle gaps → mem_read=!mem_write every cycle; req_ready=0 outside IDLE; idle gaps never change memory contents.
- Reset mid sub-word store: assert reset in the DATA state → no resp_valid; mem_write=0; after release req_ready=1 and the memory word is unchanged. With MAU_RANGE_CHECK_EN, lw @0x100 → resp_err=1; without it, lw @0x100 reads word 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte-addressed loads/stores onto a word-indexed,
// one-cycle-latency memory. Optional MAU_RANGE_CHECK_EN rejects out-of-range addresses.
module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        acc_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext, merged;

  assign req_ready = (state_q == IDLE) && !reset;

  always_comb begin
    acc_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef MAU_RANGE_CHECK_EN
    acc_err = acc_err || (req_addr[31:ADDR_W+2] != '0);
`endif
  end

`ifndef MAU_RANGE_CHECK_EN
  // High address bits are deliberately discarded (accesses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
`endif

  always_comb begin
    lane_b = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ext = {{24{lane_b[7] & !uns_q}}, lane_b};
      2'b01:   ext = {{16{lane_h[15] & !uns_q}}, lane_h};
      default: ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_write_d  = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        off_d   = req_addr[1:0];
        size_d  = req_size;
        uns_d   = req_unsigned;
        we_d    = req_we;
        wdata_d = req_wdata[15:0];
        if (acc_err) begin
          state_d      = RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
        end else begin
          mem_addr_d = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
          if (req_we && req_size == 2'b10) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = DATA;
      DATA: begin
        if (we_q) begin
          state_d     = WR;
          mem_write_d = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d      = RESP;
          resp_rdata_d = ext;
          resp_valid_d = 1'b1;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_rdata_d = '0;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d      = IDLE;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // Memory corrupts on idle cycles, so read whenever not writing.
    mem_read_d = !mem_write_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b1;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_write  = mem_write_q;
  assign mem_read   = mem_read_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
